// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: multi-cycle controller building SUB/OR/NEG/MUL from ALU ADD/AND/NOT/PASS steps
// Ports: Clk, Reset_n (async active-low); request side req_valid/req_ready/req_op/req_a/req_b;
// response side rsp_valid/rsp_ready/rsp_data; busy; ALU side alu_x/alu_y/alu_sel out, alu_out in.
module alu_op_sequencer #(
  parameter int MUL_ITER = 16
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        busy,
  output logic [15:0] alu_x,
  output logic [15:0] alu_y,
  output logic [1:0]  alu_sel,
  input  logic [15:0] alu_out
);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  state_t state, state_nx;
  logic [2:0]  op;
  logic [15:0] a, b, t, u, acc, mc;
  logic [4:0]  step, last;
  assign req_ready = state == IDLE;
  assign rsp_valid = state == DONE;
  assign busy      = state != IDLE;
  always_comb
    last = op == 3'b111 ? 5'd1 :
           op == 3'b100 ? 5'd2 :
           op == 3'b101 ? 5'd3 :
           op == 3'b110 ? 5'(2 * MUL_ITER - 1) : 5'd0;
  // ALU drive is a pure function of registered state, so no req_* path reaches the ALU
  always_comb begin
    alu_sel = 2'b11;
    alu_x   = '0;
    alu_y   = '0;
    if (state == EXEC)
      case (op)
        3'b100: begin
          alu_sel = step == 0 ? 2'b10 : 2'b00;
          alu_x   = step == 0 ? b : step == 1 ? t : a;
          alu_y   = step == 1 ? 16'd1 : t;
        end
        3'b101: begin
          alu_sel = step == 2 ? 2'b01 : 2'b10;
          alu_x   = step == 0 ? a : step == 1 ? b : t;
          alu_y   = u;
        end
        // even steps accumulate (or pass acc when the multiplier bit is 0), odd steps double mc
        3'b110: begin
          alu_sel = (step[0] || b[step[4:1]]) ? 2'b00 : 2'b11;
          alu_x   = step[0] ? mc : acc;
          alu_y   = mc;
        end
        3'b111: begin
          alu_sel = step == 0 ? 2'b10 : 2'b00;
          alu_x   = step == 0 ? a : t;
          alu_y   = step == 0 ? 16'd0 : 16'd1;
        end
        default: begin
          alu_sel = op[1:0];
          alu_x   = a;
          alu_y   = b;
        end
      endcase
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = req_valid ? EXEC : IDLE;
      EXEC:    state_nx = step == last ? DONE : EXEC;
      default: state_nx = rsp_ready ? IDLE : DONE;
    endcase
  end
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      state    <= IDLE;
      op       <= '0;
      a        <= '0;
      b        <= '0;
      t        <= '0;
      u        <= '0;
      acc      <= '0;
      mc       <= '0;
      step     <= '0;
      rsp_data <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && req_valid) begin
        op   <= req_op;
        a    <= req_a;
        b    <= req_b;
        step <= '0;
        acc  <= '0;
        mc   <= req_a;
      end
      if (state == EXEC) begin
        step <= step + 5'd1;
        if (op == 3'b110) begin
          if (step[0]) mc <= alu_out;
          else acc <= alu_out;
        end else if (op == 3'b101 && step == 1) u <= alu_out;
        else t <= alu_out;
        // MUL ends on a doubling step, so its product is already sitting in acc
        if (step == last) rsp_data <= op == 3'b110 ? acc : alu_out;
      end
    end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed self-checking bench for alu_op_sequencer with a behavioural ALU
module tb_alu_op_sequencer;
  logic        Clk = 0, Reset_n = 0;
  logic        req_valid = 0, rsp_ready = 0;
  logic [2:0]  req_op = '0;
  logic [15:0] req_a = '0, req_b = '0;
  logic        req_ready, rsp_valid, busy;
  logic [15:0] rsp_data, alu_x, alu_y, alu_out;
  logic [1:0]  alu_sel;
  logic [1:0]  sel_log [32];
  int checks = 0, errors = 0;
  alu_op_sequencer dut (
    .Clk(Clk), .Reset_n(Reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .busy(busy), .alu_x(alu_x),
    .alu_y(alu_y), .alu_sel(alu_sel), .alu_out(alu_out)
  );
  always_comb
    alu_out = alu_sel == 2'b00 ? alu_x + alu_y :
              alu_sel == 2'b01 ? alu_x & alu_y :
              alu_sel == 2'b10 ? ~alu_x : alu_x;
  always #5 Clk = ~Clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask
  task automatic run(input string tag, input logic [2:0] o, input logic [15:0] x, input logic [15:0] y,
                     input logic [15:0] e, input int n);
    req_op = o; req_a = x; req_b = y; req_valid = 1;
    @(posedge Clk); #1 req_valid = 0;
    for (int k = 1; k <= n; k++) begin
      sel_log[k-1] = alu_sel;
      @(posedge Clk); #1;
      if (k == n - 1) chk({tag, " early"}, rsp_valid, 0);
    end
    chk({tag, " valid"}, rsp_valid, 1);
    chk({tag, " data"}, rsp_data, e);
  endtask
  task automatic consume(input string tag);
    rsp_ready = 1;
    @(posedge Clk); #1 rsp_ready = 0;
    chk({tag, " idle"}, {req_ready, rsp_valid, busy}, 3'b100);
  endtask
  initial begin
    #12;
    chk("rst outs", {req_ready, rsp_valid, busy, alu_sel}, 5'b10011);
    chk("rst data", {rsp_data, alu_x, alu_y}, 48'h0);
    @(negedge Clk) Reset_n = 1;
    run("sub", 3'b100, 16'd5, 16'd7, 16'hFFFE, 3);
    chk("sub sels", {sel_log[0], sel_log[1], sel_log[2]}, 6'b100000);
    chk("done alu", {alu_sel, alu_x, alu_y}, {2'b11, 32'h0});
    consume("sub");
    run("or", 3'b101, 16'h00F0, 16'h0F0F, 16'h0FFF, 4);
    consume("or");
    run("add wrap", 3'b000, 16'hFFFF, 16'h0001, 16'h0000, 1);
    consume("add wrap");
    run("not", 3'b010, 16'h00FF, 16'h1234, 16'hFF00, 1);
    consume("not");
    run("mul", 3'b110, 16'd300, 16'd300, 16'h5F90, 32);
    consume("mul");
    run("mul zero", 3'b110, 16'h1234, 16'h0000, 16'h0000, 32);
    consume("mul zero");
    run("neg 8000", 3'b111, 16'h8000, 16'h0000, 16'h8000, 2);
    consume("neg 8000");
    run("neg 1", 3'b111, 16'h0001, 16'h0000, 16'hFFFF, 2);
    consume("neg 1");
    run("bp add", 3'b000, 16'd1, 16'd2, 16'd3, 1);
    req_op = 3'b001; req_a = 16'h00FF; req_b = 16'h0F0F; req_valid = 1;
    for (int k = 0; k < 5; k++) begin
      @(posedge Clk); #1;
      chk("bp hold", {rsp_valid, req_ready, busy, rsp_data}, {3'b101, 16'd3});
    end
    rsp_ready = 1;
    @(posedge Clk); #1 rsp_ready = 0;
    chk("bp bubble", {req_ready, rsp_valid, busy}, 3'b100);
    @(posedge Clk); #1 req_valid = 0;
    chk("bp accept", {req_ready, busy}, 2'b01);
    @(posedge Clk); #1;
    chk("bp and", {rsp_valid, rsp_data}, {1'b1, 16'h000F});
    consume("bp and");
    req_op = 3'b110; req_a = 16'd300; req_b = 16'd300; req_valid = 1;
    @(posedge Clk); #1 req_valid = 0;
    repeat (10) @(posedge Clk);
    #2 Reset_n = 0;
    #1;
    chk("abort", {rsp_valid, req_ready, busy, alu_sel}, 5'b01011);
    chk("abort data", {rsp_data, alu_x, alu_y}, 48'h0);
    @(negedge Clk) Reset_n = 1;
    run("post add", 3'b000, 16'd2, 16'd3, 16'd5, 1);
    consume("post add");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
